// File: rtl/timing_pkg.sv
// Shared types and constants for the T-state step generator.
package timing_pkg;
  localparam int STEP_W = 3;
  typedef logic [STEP_W-1:0] step_t;
  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} tstate_t;
  localparam logic [7:0] ONEHOT_T0 = 8'h01;
endpackage

// File: rtl/step_decoder_3x8.sv
// Combinational 3-to-8 one-hot step decoder; en=0 forces an all-zero bus.
module step_decoder_3x8
  import timing_pkg::*;
(
  input  step_t      step,
  input  logic       en,
  output logic [7:0] onehot
);
  // Tk is bit k; the bus is blanked while the sequencer is halted.
  always_comb begin
    onehot = 8'h00;
    if (en) onehot = ONEHOT_T0 << step;
  end
endmodule

// File: rtl/timing_step_decoder.sv
// Control-step (T-state) generator: binary step counter with registered
// one-hot decode, wait-state hold, end-of-instruction clear and halt.
// Optional feature macro: TIMING_STEP_LOAD_EN adds a direct step load
// (load / load_step) ranked below clr_step and above hold.
module timing_step_decoder
  import timing_pkg::*;
#(
  parameter int N_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  input  logic       clr_step,
  input  logic       halt,
  input  logic       resume,
`ifdef TIMING_STEP_LOAD_EN
  input  logic       load,
  input  logic [2:0] load_step,
`endif
  output logic [7:0] t_onehot,
  output logic [2:0] t_bin,
  output logic       first_step,
  output logic       last_step,
  output logic       halted
);
  localparam step_t LAST = step_t'(N_STEPS - 1);

  tstate_t    state, nxt_state;
  step_t      nxt_bin;
  logic [7:0] nxt_onehot;
  logic       nxt_run;

  // Next state and next step; every output is derived from these two so
  // all of them move together on the same edge.
  always_comb begin
    nxt_state = state;
    nxt_bin   = t_bin;
    if (state == HALTED) begin
      if (resume) begin
        nxt_state = RUN;
        nxt_bin   = '0;
      end
    end else if (halt) begin
      nxt_state = HALTED;
      nxt_bin   = '0;
    end else if (clr_step) begin
      nxt_bin = '0;
`ifdef TIMING_STEP_LOAD_EN
    end else if (load) begin
      // Out-of-range steps fall back to T0 so the one-hot stays in range.
      nxt_bin = (int'(load_step) < N_STEPS) ? load_step : '0;
`endif
    end else if (hold) begin
      nxt_bin = t_bin;
    end else if (en) begin
      nxt_bin = (t_bin == LAST) ? '0 : t_bin + 3'd1;
    end
  end

  assign nxt_run = (nxt_state == RUN);

  // Decode sits on the next-state path so t_onehot is a plain register.
  step_decoder_3x8 u_dec (
    .step   (nxt_bin),
    .en     (nxt_run),
    .onehot (nxt_onehot)
  );

  // Output and state registers; reset lands on T0 in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      t_bin      <= '0;
      t_onehot   <= ONEHOT_T0;
      first_step <= 1'b1;
      last_step  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= nxt_state;
      t_bin      <= nxt_bin;
      t_onehot   <= nxt_onehot;
      first_step <= nxt_run && (nxt_bin == '0);
      last_step  <= nxt_run && (nxt_bin == LAST);
      halted     <= !nxt_run;
    end
  end
endmodule

// File: tb/tb_timing_step_decoder.sv
// Random + directed bench: two instances (N_STEPS=8 and 5) share stimulus
// and are compared each cycle against a step/halt reference model.
module tb_timing_step_decoder;
  logic clk = 1'b0;
  logic rst, en, hold, clr_step, halt, resume;
`ifdef TIMING_STEP_LOAD_EN
  logic       load;
  logic [2:0] load_step;
`endif
  logic [7:0] oh   [2];
  logic [2:0] bin  [2];
  logic       fst  [2];
  logic       lst  [2];
  logic       hlt  [2];

  int n_vec = 0;
  int n_err = 0;
  int nst   [2] = '{8, 5};
  int m_step[2];
  bit m_halt[2];

  always #5 clk = ~clk;

  timing_step_decoder #(.N_STEPS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .clr_step(clr_step),
    .halt(halt), .resume(resume),
`ifdef TIMING_STEP_LOAD_EN
    .load(load), .load_step(load_step),
`endif
    .t_onehot(oh[0]), .t_bin(bin[0]), .first_step(fst[0]),
    .last_step(lst[0]), .halted(hlt[0]));

  timing_step_decoder #(.N_STEPS(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .clr_step(clr_step),
    .halt(halt), .resume(resume),
`ifdef TIMING_STEP_LOAD_EN
    .load(load), .load_step(load_step),
`endif
    .t_onehot(oh[1]), .t_bin(bin[1]), .first_step(fst[1]),
    .last_step(lst[1]), .halted(hlt[1]));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: behaviour by rule, applied to one instance per edge.
  task automatic model(input int i);
    if (rst) begin
      m_step[i] = 0; m_halt[i] = 0;
    end else if (m_halt[i]) begin
      if (resume) begin m_halt[i] = 0; m_step[i] = 0; end
    end else if (halt) begin
      m_halt[i] = 1; m_step[i] = 0;
    end else if (clr_step) begin
      m_step[i] = 0;
`ifdef TIMING_STEP_LOAD_EN
    end else if (load) begin
      m_step[i] = (int'(load_step) < nst[i]) ? int'(load_step) : 0;
`endif
    end else if (hold) begin
      m_step[i] = m_step[i];
    end else if (en) begin
      m_step[i] = (m_step[i] + 1) % nst[i];
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e_oh;
      e_oh = m_halt[i] ? 8'h00 : 8'(1 << m_step[i]);
      chk($sformatf("onehot%0d", nst[i]), 16'(oh[i]), 16'(e_oh));
      chk($sformatf("bin%0d", nst[i]), 16'(bin[i]), 16'(m_step[i]));
      chk($sformatf("flags%0d", nst[i]), 16'({fst[i], lst[i], hlt[i]}),
          16'({!m_halt[i] && m_step[i] == 0,
               !m_halt[i] && m_step[i] == nst[i] - 1, m_halt[i]}));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model(i);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; en = 0; hold = 0; clr_step = 0; halt = 0; resume = 0;
`ifdef TIMING_STEP_LOAD_EN
    load = 0; load_step = 3'd0;
`endif
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk("rst_onehot", 16'(oh[0]), 16'h0001);
    chk("rst_flags", 16'({fst[0], lst[0], hlt[0]}), 16'b100);
    rst = 0;

    // Ten advances: N=8 ends on 2 after wrapping through 7.
    en = 1;
    for (int k = 0; k < 10; k++) tick();
    chk("wrap_bin8", 16'(bin[0]), 16'd2);
    chk("wrap_oh5", 16'(oh[1]), 16'h0001); // 10 % 5 == 0

    // Hold at step 3 for three cycles, then release.
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 3; k++) tick();
    hold = 1;
    for (int k = 0; k < 3; k++) tick();
    chk("hold_oh8", 16'(oh[0]), 16'h0008);
    hold = 0; tick();
    chk("post_hold8", 16'(bin[0]), 16'd4);

    // Step 5: clr_step wins over hold.
    tick();
    chk("at5", 16'(bin[0]), 16'd5);
    clr_step = 1; hold = 1; tick();
    chk("clr_oh8", 16'(oh[0]), 16'h0001);
    clr_step = 0; hold = 0;

    // Halt at step 2, poke it, then resume.
    tick(); tick();
    halt = 1; tick(); halt = 0;
    chk("halt_oh8", 16'(oh[0]), 16'h0000);
    for (int k = 0; k < 4; k++) begin clr_step = k[0]; tick(); end
    clr_step = 0; resume = 1; tick(); resume = 0;
    chk("resume_oh8", 16'(oh[0]), 16'h0001);

    // Reset during hold at step 6.
    for (int k = 0; k < 6; k++) tick();
    hold = 1; tick();
    rst = 1; tick(); rst = 0; hold = 0;
    chk("rst_hold_fst", 16'(fst[0]), 16'd1);

`ifdef TIMING_STEP_LOAD_EN
    en = 0; load = 1; load_step = 3'd6; tick();
    chk("load6_8", 16'(bin[0]), 16'd6);
    chk("load6_5", 16'(bin[1]), 16'd0);
    load_step = 3'd7; tick(); load = 0;
    chk("load7_8", 16'(bin[0]), 16'd7);
`endif

    // Random phase.
    for (int k = 0; k < 800; k++) begin
      rst      = ($urandom_range(99) < 2);
      en       = ($urandom_range(99) < 75);
      hold     = ($urandom_range(99) < 15);
      clr_step = ($urandom_range(99) < 8);
      halt     = ($urandom_range(99) < 3);
      resume   = ($urandom_range(99) < 20);
`ifdef TIMING_STEP_LOAD_EN
      load      = ($urandom_range(99) < 8);
      load_step = 3'($urandom_range(7));
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
